// File: rtl/csi2_tx_packetizer.sv
// Two-lane CSI-2 transmit packetizer: LP entry, HS-zero, sync, ECC header,
// CRC-protected payload and HS trail. Each lane emits 2 bits per mipi_clk cycle.
module csi2_tx_packetizer #(
  parameter int unsigned TLPX_CYC    = 2,
  parameter int unsigned HS_ZERO_CYC = 8,
  parameter int unsigned TRAIL_CYC   = 4
) (
  input  logic        mipi_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  vc,
  input  logic [5:0]  data_type,
  input  logic [15:0] word_count,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [1:0]  lane0_q,
  output logic [1:0]  lane1_q,
  output logic        hs_oe,
  output logic        lp_p,
  output logic        lp_n,
  output logic        busy,
  output logic        done,
  output logic        err_odd_wc,
  output logic        underrun
);

  typedef enum logic [3:0] {
    IDLE, LP01, LP00, HS_ZERO, SYNC, HEADER, PAYLOAD, CRC, TRAIL
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt;
  logic [1:0]  vc_r;
  logic [5:0]  dt_r;
  logic [15:0] wc_r;
  logic [15:0] pix_r;
  logic [15:0] crc;
  logic        last0, last1;
  logic        accept, is_long, data_phase;
  logic [31:0] hdr;
  logic [15:0] pair_in;
  logic [7:0]  byte0, byte1;

  // CSI-2 6-bit Hamming over the 24 header bits; identical to the receiver check.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CRC-16 (0x8408) over one byte pair: lane0 byte first, LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] pr);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 16; i++)
      r = (r >> 1) ^ (((r[0] ^ pr[i]) == 1'b1) ? 16'h8408 : 16'h0000);
    return r;
  endfunction

  assign is_long    = (dt_r >= 6'h10);
  assign hdr        = {2'b00, calc_ecc({wc_r, vc_r, dt_r}), wc_r, vc_r, dt_r};
  assign err_odd_wc = (state == IDLE) && start && (data_type >= 6'h10) && word_count[0];
  assign accept     = (state == IDLE) && start && !err_odd_wc;
  assign pair_in    = pix_valid ? pix_data : '0;
  assign underrun   = pix_ready && !pix_valid;
  assign busy       = (state != IDLE);

  // State and cycle-counter register; reset aborts immediately without a trail.
  always_ff @(posedge mipi_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state sequencing plus the pix_ready and done strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 17'd1;
    pix_ready = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = LP01;
      end
      LP01: if (cnt == 17'(TLPX_CYC - 1)) begin state_nxt = LP00; cnt_nxt = '0; end
      LP00: if (cnt == 17'(TLPX_CYC - 1)) begin state_nxt = HS_ZERO; cnt_nxt = '0; end
      HS_ZERO: if (cnt == 17'(HS_ZERO_CYC - 1)) begin state_nxt = SYNC; cnt_nxt = '0; end
      SYNC: if (cnt == 17'd3) begin state_nxt = HEADER; cnt_nxt = '0; end
      HEADER: begin
        pix_ready = is_long && (wc_r != 16'd0) && (cnt == 17'd7);
        if (cnt == 17'd7) begin
          cnt_nxt = '0;
          if (!is_long)           state_nxt = TRAIL;
          else if (wc_r == 16'd0) state_nxt = CRC;
          else                    state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // cnt runs over 2*wc cycles: wc/2 slots of 4 cycles each
        if (cnt == {wc_r, 1'b0} - 17'd1) begin
          state_nxt = CRC;
          cnt_nxt   = '0;
        end else begin
          pix_ready = (cnt[1:0] == 2'd3);
        end
      end
      CRC: if (cnt == 17'd3) begin state_nxt = TRAIL; cnt_nxt = '0; end
      TRAIL: begin
        if (cnt == 17'(TRAIL_CYC - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched packet fields, payload pair, running CRC and last-bit memory for the trail.
  always_ff @(posedge mipi_clk) begin
    if (reset) begin
      vc_r  <= '0;
      dt_r  <= '0;
      wc_r  <= '0;
      pix_r <= '0;
      crc   <= '1;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      if (accept) begin
        vc_r <= vc;
        dt_r <= data_type;
        wc_r <= word_count;
        crc  <= '1;
      end
      if (pix_ready) begin
        pix_r <= pair_in;
        crc   <= crc_step(crc, pair_in);
      end
      if (data_phase) begin
        last0 <= lane0_q[1];
        last1 <= lane1_q[1];
      end
    end
  end

  // Lane serialiser: byte selection per state, two bits per cycle LSB first.
  always_comb begin
    byte0      = '0;
    byte1      = '0;
    data_phase = 1'b0;
    lane0_q    = 2'b00;
    lane1_q    = 2'b00;
    unique case (state)
      SYNC:    begin byte0 = 8'hB8; byte1 = 8'hB8; data_phase = 1'b1; end
      HEADER: begin
        data_phase = 1'b1;
        byte0 = cnt[2] ? hdr[23:16] : hdr[7:0];
        byte1 = cnt[2] ? hdr[31:24] : hdr[15:8];
      end
      PAYLOAD: begin byte0 = pix_r[7:0]; byte1 = pix_r[15:8]; data_phase = 1'b1; end
      CRC:     begin byte0 = crc[7:0];   byte1 = crc[15:8];   data_phase = 1'b1; end
      default: ;
    endcase
    if (data_phase) begin
      lane0_q = byte0[{cnt[1:0], 1'b0} +: 2];
      lane1_q = byte1[{cnt[1:0], 1'b0} +: 2];
    end else if (state == TRAIL) begin
      lane0_q = {2{~last0}};
      lane1_q = {2{~last1}};
    end
  end

  // LP line levels and HS driver enable per state.
  always_comb begin
    lp_p  = 1'b0;
    lp_n  = 1'b0;
    hs_oe = 1'b0;
    unique case (state)
      IDLE:    begin lp_p = 1'b1; lp_n = 1'b1; end
      LP01:    lp_n = 1'b1;
      LP00:    ;
      default: hs_oe = 1'b1;
    endcase
  end

endmodule
